// File: rtl/regfile_wr_arbiter.sv
// rtl/regfile_wr_arbiter.sv - round-robin write-port arbiter with burst lock for the 8 x 16-bit register file
module regfile_wr_arbiter #(
  parameter int NREQ     = 3,
  parameter int DW       = 16,
  parameter int AW       = 3,
  parameter int LOCK_MAX = 15
) (
  input  logic                  clk,
  input  logic                  rst_b,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_last,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*DW-1:0]    req_data,
  output logic [NREQ-1:0]       req_ready,
  input  logic                  wr_stall,
  output logic [(1<<AW)-1:0]    reg_en,
  output logic [DW-1:0]         reg_wdata,
  output logic                  lock_active,
  output logic [1:0]            lock_owner,
  output logic                  lock_abort
);

  localparam int NREG = 1 << AW;

  typedef enum logic {S_IDLE = 1'b0, S_LOCK = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      owner_q, owner_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [NREG-1:0] en_q, en_d;
  logic [DW-1:0]   wdata_q, wdata_d;

  logic            found;
  logic [1:0]      win;
  logic [1:0]      cand;
  logic            acc;
  logic            abort;
  logic [1:0]      sel;

  function automatic logic [1:0] next_idx(input logic [1:0] v);
    return (v == 2'(NREQ - 1)) ? 2'd0 : v + 2'd1;
  endfunction

  // Round-robin scan: first valid requester starting at the priority pointer
  always_comb begin
    found = 1'b0;
    win   = ptr_q;
    cand  = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
      cand = next_idx(cand);
    end
  end

  // Output decode: ready, acceptance and timeout abort; stall and reset silence everything
  always_comb begin
    req_ready = '0;
    acc       = 1'b0;
    abort     = 1'b0;
    sel       = owner_q;
    if (rst_b && !wr_stall) begin
      if (state_q == S_IDLE) begin
        if (found) begin
          req_ready[win] = 1'b1;
          acc            = 1'b1;
          sel            = win;
        end
      end else if (cnt_q == 8'(LOCK_MAX)) begin
        // Forced release cycle: the owner gets no ready even if it came back
        abort = 1'b1;
      end else begin
        req_ready[owner_q] = 1'b1;
        acc                = req_valid[owner_q];
      end
    end
  end

  // Next-state: arbitration state, pointer, owner, idle counter and write-port values
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    en_d    = '0;
    wdata_d = wdata_q;
    if (acc) begin
      en_d    = NREG'(1) << req_addr[int'(sel)*AW +: AW];
      wdata_d = req_data[int'(sel)*DW +: DW];
    end
    if (!wr_stall) begin
      case (state_q)
        S_IDLE: begin
          if (acc) begin
            owner_d = sel;
            cnt_d   = 8'd0;
            if (req_last[sel]) begin
              ptr_d = next_idx(sel);
            end else begin
              state_d = S_LOCK;
            end
          end
        end
        default: begin
          if (abort) begin
            state_d = S_IDLE;
            ptr_d   = next_idx(owner_q);
            cnt_d   = 8'd0;
          end else if (acc) begin
            cnt_d = 8'd0;
            if (req_last[owner_q]) begin
              state_d = S_IDLE;
              ptr_d   = next_idx(owner_q);
            end
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      endcase
    end
  end

  // State register with asynchronous clear; an abandoned burst issues no further writes
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd0;
      owner_q <= 2'd0;
      cnt_q   <= 8'd0;
      en_q    <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
      wdata_q <= wdata_d;
    end
  end

  assign reg_en      = en_q;
  assign reg_wdata   = wdata_q;
  assign lock_active = (state_q == S_LOCK);
  assign lock_owner  = owner_q;
  assign lock_abort  = abort;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb/tb_regfile_wr_arbiter.sv - directed and randomized bench for regfile_wr_arbiter with a behavioural model
module tb_regfile_wr_arbiter;

  localparam int NREQ     = 3;
  localparam int DW       = 16;
  localparam int AW       = 3;
  localparam int NREG     = 8;
  localparam int LOCK_MAX = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_b;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_last;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 wr_stall;
  logic [NREG-1:0]      reg_en;
  logic [DW-1:0]        reg_wdata;
  logic                 lock_active;
  logic [1:0]           lock_owner;
  logic                 lock_abort;

  logic [AW-1:0] a [NREQ];
  logic [DW-1:0] d [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_addr[g*AW +: AW] = a[g];
    assign req_data[g*DW +: DW] = d[g];
  end

  regfile_wr_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_valid  (req_valid),
    .req_last   (req_last),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .wr_stall   (wr_stall),
    .reg_en     (reg_en),
    .reg_wdata  (reg_wdata),
    .lock_active(lock_active),
    .lock_owner (lock_owner),
    .lock_abort (lock_abort)
  );

  // Reference model state
  int            m_ptr, m_owner, m_idle;
  bit            m_lock;
  logic [NREG-1:0] m_en;
  logic [DW-1:0] m_wdata;

  int            checks = 0;
  int            errors = 0;
  bit            acc;
  int            acc_sel;
  logic [NREQ-1:0] obs_ready;
  int            aborts;
  int            order [4] = '{0, 1, 2, 0};
  int            g2;
  int            rem [NREQ];
  int            gap [NREQ];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_idle = 0; m_lock = 0; m_en = '0; m_wdata = '0;
  endtask

  // One clock cycle: predict handshake at negedge, check write port and lock state after the edge
  task automatic step();
    logic [NREQ-1:0] er;
    bit ea;
    @(negedge clk);
    er = '0; ea = 0; acc = 0; acc_sel = 0;
    if (!wr_stall) begin
      if (!m_lock) begin
        for (int k = 0; k < NREQ; k++) begin
          int i = (m_ptr + k) % NREQ;
          if (!acc && req_valid[i]) begin acc = 1; acc_sel = i; end
        end
        if (acc) er[acc_sel] = 1'b1;
      end else if (m_idle == LOCK_MAX) begin
        ea = 1;
      end else begin
        er[m_owner] = 1'b1;
        acc = req_valid[m_owner];
        acc_sel = m_owner;
      end
    end
    obs_ready = req_ready;
    if (lock_abort) aborts++;
    chk("ready", 32'(req_ready), 32'(er));
    chk("abort", 32'(lock_abort), 32'(ea));
    @(posedge clk); #1;
    m_en = '0;
    if (acc) begin
      m_en = NREG'(1) << a[acc_sel];
      m_wdata = d[acc_sel];
    end
    if (!wr_stall) begin
      if (ea) begin
        m_lock = 0; m_ptr = (m_owner + 1) % NREQ; m_idle = 0;
      end else if (acc) begin
        m_owner = acc_sel; m_idle = 0;
        if (req_last[acc_sel]) begin m_lock = 0; m_ptr = (acc_sel + 1) % NREQ; end
        else m_lock = 1;
      end else if (m_lock) begin
        m_idle++;
      end
    end
    chk("reg_en", 32'(reg_en), 32'(m_en));
    chk("reg_wdata", 32'(reg_wdata), 32'(m_wdata));
    chk("lock_active", 32'(lock_active), 32'(m_lock));
    chk("lock_owner", 32'(lock_owner), 32'(m_owner));
  endtask

  task automatic do_reset();
    req_valid = '0; wr_stall = 1'b0; rst_b = 1'b0;
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
  endtask

  initial begin
    rst_b = 1'b0; req_valid = '0; req_last = '0; wr_stall = 1'b0; aborts = 0;
    for (int i = 0; i < NREQ; i++) begin a[i] = '0; d[i] = '0; rem[i] = 0; gap[i] = 0; end
    model_reset();
    #12;
    chk("rst_en", 32'(reg_en), 32'h0);
    chk("rst_wdata", 32'(reg_wdata), 32'h0);
    chk("rst_lock", 32'(lock_active), 32'h0);
    chk("rst_owner", 32'(lock_owner), 32'h0);
    chk("rst_abort", 32'(lock_abort), 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;

    // Round-robin with all three valid single-beat writers
    req_valid = 3'b111; req_last = 3'b111;
    a[0] = 3'd1; a[1] = 3'd2; a[2] = 3'd3;
    d[0] = 16'hAAAA; d[1] = 16'hBBBB; d[2] = 16'hCCCC;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_ready", 32'(obs_ready), 32'(1) << order[k]);
      chk("rr_en", 32'(reg_en), 32'(2) << order[k]);
    end

    // Burst from req1 into R4..R7 while req0 and req2 compete
    do_reset();
    req_valid = 3'b001; req_last = 3'b111; a[0] = 3'd0; d[0] = 16'h1111;
    step();
    req_valid = 3'b111; req_last = 3'b101;
    a[1] = 3'd4; a[2] = 3'd2; d[2] = 16'h2222;
    for (int k = 0; k < 4; k++) begin
      d[1] = 16'h4000 + 16'(k);
      step();
      chk("burst_ready", 32'(obs_ready), 32'h2);
      chk("burst_en", 32'(reg_en), 32'h10 << k);
      a[1] = a[1] + 3'd1;
      req_last[1] = (a[1] == 3'd7);
      if (k == 3) req_valid[1] = 1'b0;
    end
    step();
    chk("burst_next", 32'(obs_ready), 32'h4);

    // Lock timeout: owner goes silent after a non-last beat
    do_reset();
    aborts = 0; g2 = -1;
    req_valid = 3'b010; req_last = 3'b000; a[1] = 3'd6; d[1] = 16'h6666;
    step();
    req_valid = 3'b100; req_last = 3'b100; a[2] = 3'd2; d[2] = 16'h7777;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (obs_ready[2] && g2 < 0) begin g2 = k; req_valid[2] = 1'b0; end
    end
    chk("to_aborts", 32'(aborts), 32'd1);
    chk("to_grant_cycle", 32'(g2), 32'd17);

    // Stall holds off a valid requester; beat goes in the cycle stall drops
    do_reset();
    wr_stall = 1'b1; req_valid = 3'b001; req_last = 3'b001; a[0] = 3'd5; d[0] = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_ready", 32'(obs_ready), 32'h0);
      chk("stall_en", 32'(reg_en), 32'h0);
    end
    wr_stall = 1'b0;
    step();
    chk("unstall_ready", 32'(obs_ready), 32'h1);
    chk("unstall_en", 32'(reg_en), 32'h20);
    req_valid = '0;

    // Write latency: visible exactly one cycle after acceptance
    req_valid = 3'b001; req_last = 3'b001; a[0] = 3'd7; d[0] = 16'hBEEF;
    step();
    chk("lat_en", 32'(reg_en), 32'h80);
    chk("lat_wdata", 32'(reg_wdata), 32'hBEEF);
    req_valid = '0;
    step();
    chk("lat_en_after", 32'(reg_en), 32'h0);
    chk("lat_wdata_hold", 32'(reg_wdata), 32'hBEEF);

    // Asynchronous reset in the middle of a burst
    do_reset();
    req_valid = 3'b001; req_last = 3'b000; a[0] = 3'd1; d[0] = 16'h0101;
    step();
    a[0] = 3'd2; d[0] = 16'h0202;
    step();
    #2 rst_b = 1'b0;
    #1;
    chk("arst_en", 32'(reg_en), 32'h0);
    chk("arst_lock", 32'(lock_active), 32'h0);
    chk("arst_ready", 32'(req_ready), 32'h0);
    chk("arst_wdata", 32'(reg_wdata), 32'h0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    model_reset();
    req_valid = 3'b111; req_last = 3'b111;
    step();
    chk("arst_first", 32'(obs_ready), 32'h1);

    // Randomized traffic with bursts, gaps long enough to time out, and stalls
    do_reset();
    for (int i = 0; i < NREQ; i++) begin rem[i] = 0; gap[i] = 0; end
    repeat (600) begin
      wr_stall = ($urandom_range(0, 9) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i]) begin
          if (gap[i] > 0) gap[i]--;
          else if (rem[i] > 0 || $urandom_range(0, 2) == 0) begin
            if (rem[i] == 0) rem[i] = $urandom_range(1, 4);
            req_valid[i] = 1'b1;
            a[i] = AW'($urandom);
            d[i] = DW'($urandom);
            req_last[i] = (rem[i] == 1);
          end
        end
      end
      step();
      if (acc) begin
        rem[acc_sel]--;
        req_valid[acc_sel] = 1'b0;
        if (rem[acc_sel] > 0 && $urandom_range(0, 4) == 0) gap[acc_sel] = $urandom_range(5, 20);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
